// File: rtl/id_ex_issue.sv
// id_ex_issue: decodes an RV32 subset into ALU control/operands and holds it in a
// single-entry ID/EX register with valid/ready handshake, flush and illegal counting.
module id_ex_issue #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_rs1_data,
  input  logic [31:0]      in_rs2_data,
  input  logic             flush,
  input  logic             ex_ready,
  output logic             ex_valid,
  output logic [3:0]       ex_alu_control,
  output logic [31:0]      ex_src_a,
  output logic [31:0]      ex_src_b,
  output logic [31:0]      ex_rs2_data,
  output logic [4:0]       ex_rd,
  output logic             ex_reg_write,
  output logic             ex_mem_write,
  output logic             ex_result_src,
  output logic             ex_illegal,
  output logic [CNT_W-1:0] illegal_count
);
  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_L = 7'b0000011;
  localparam logic [6:0] OP_S = 7'b0100011;
  logic [6:0] op, f7;
  logic [2:0] f3;
  logic [4:0] rd;
  logic is_r, is_i, is_l, is_s, legal, accept, unused;
  logic [3:0] alu_d, alu_q;
  logic [31:0] src_a_d, src_b_d, src_a_q, src_b_q, rs2_q;
  logic [4:0] rd_q;
  logic reg_write_d, valid_q, reg_write_q, mem_write_q, result_src_q, illegal_q;
  logic [CNT_W-1:0] cnt_q;
  assign op = in_instr[6:0];
  assign f3 = in_instr[14:12];
  assign f7 = in_instr[31:25];
  assign rd = in_instr[11:7];
  assign unused = ^in_instr[19:15];
  assign is_r = op == OP_R && f7 == 7'd0 && f3 inside {3'b000, 3'b111, 3'b110, 3'b001};
  assign is_i = op == OP_I && (f3 inside {3'b000, 3'b111, 3'b110} || (f3 == 3'b001 && f7 == 7'd0));
  assign is_l = op == OP_L && f3 == 3'b010;
  assign is_s = op == OP_S && f3 == 3'b010;
  assign legal = is_r || is_i || is_l || is_s;
  always_comb begin
    alu_d = !(is_r || is_i) ? 4'b0000 :
            f3 == 3'b111 ? 4'b0001 :
            f3 == 3'b110 ? 4'b0011 :
            f3 == 3'b001 ? 4'b0100 : 4'b0000;
    src_a_d = legal ? in_rs1_data : 32'd0;
    src_b_d = is_r ? in_rs2_data :
              (is_i && f3 == 3'b001) ? {27'd0, in_instr[24:20]} :
              (is_i || is_l) ? {{20{in_instr[31]}}, in_instr[31:20]} :
              is_s ? {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]} : 32'd0;
    reg_write_d = (is_r || is_i || is_l) && rd != 5'd0;
  end
  assign in_ready = !valid_q || ex_ready;
  assign accept = in_valid && in_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      alu_q <= 4'd0;
      src_a_q <= 32'd0;
      src_b_q <= 32'd0;
      rs2_q <= 32'd0;
      rd_q <= 5'd0;
      reg_write_q <= 1'b0;
      mem_write_q <= 1'b0;
      result_src_q <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
      reg_write_q <= 1'b0;
      mem_write_q <= 1'b0;
      result_src_q <= 1'b0;
      illegal_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      alu_q <= alu_d;
      src_a_q <= src_a_d;
      src_b_q <= src_b_d;
      rs2_q <= in_rs2_data;
      rd_q <= rd;
      reg_write_q <= reg_write_d;
      mem_write_q <= is_s;
      result_src_q <= is_l;
      illegal_q <= !legal;
      cnt_q <= cnt_q + CNT_W'(!legal && cnt_q != '1);
    end else if (ex_ready) begin
      valid_q <= 1'b0;
    end
  end
  assign ex_valid = valid_q;
  assign ex_alu_control = alu_q;
  assign ex_src_a = src_a_q;
  assign ex_src_b = src_b_q;
  assign ex_rs2_data = rs2_q;
  assign ex_rd = rd_q;
  assign ex_reg_write = reg_write_q;
  assign ex_mem_write = mem_write_q;
  assign ex_result_src = result_src_q;
  assign ex_illegal = illegal_q;
  assign illegal_count = cnt_q;
endmodule

// File: tb/tb_id_ex_issue.sv
// tb_id_ex_issue: directed vectors into a scoreboard; a monitor pops and compares
// every instruction the execute stage consumes.
module tb_id_ex_issue;
  typedef struct packed {
    logic [3:0]  alu;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic        rw;
    logic        mw;
    logic        rs;
    logic        ill;
  } exp_t;
  logic clk = 0, rst = 1, in_valid = 0, flush = 0, ex_ready = 0;
  logic [31:0] in_instr = 0, in_rs1_data = 0, in_rs2_data = 0;
  logic in_ready, ex_valid, ex_reg_write, ex_mem_write, ex_result_src, ex_illegal;
  logic [3:0] ex_alu_control;
  logic [31:0] ex_src_a, ex_src_b, ex_rs2_data;
  logic [4:0] ex_rd;
  logic [15:0] illegal_count;
  logic d2_in_ready, d2_valid, d2_rw, d2_mw, d2_rs, d2_ill;
  logic [3:0] d2_alu;
  logic [31:0] d2_a, d2_b, d2_rs2;
  logic [4:0] d2_rd;
  logic [1:0] d2_count;
  int compared = 0, mismatched = 0;
  exp_t q[$];
  bit imm;
  exp_t A, B;

  id_ex_issue dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .flush(flush), .ex_ready(ex_ready),
    .ex_valid(ex_valid), .ex_alu_control(ex_alu_control), .ex_src_a(ex_src_a), .ex_src_b(ex_src_b),
    .ex_rs2_data(ex_rs2_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_write(ex_mem_write),
    .ex_result_src(ex_result_src), .ex_illegal(ex_illegal), .illegal_count(illegal_count));

  // narrow-counter copy fed the same stream, to reach saturation quickly
  id_ex_issue #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d2_in_ready), .in_instr(in_instr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .flush(flush), .ex_ready(ex_ready),
    .ex_valid(d2_valid), .ex_alu_control(d2_alu), .ex_src_a(d2_a), .ex_src_b(d2_b),
    .ex_rs2_data(d2_rs2), .ex_rd(d2_rd), .ex_reg_write(d2_rw), .ex_mem_write(d2_mw),
    .ex_result_src(d2_rs), .ex_illegal(d2_ill), .illegal_count(d2_count));

  always #5 clk = ~clk;

  function automatic exp_t E(logic [3:0] alu, logic [31:0] a, b, rs2, logic [4:0] rd,
                             logic rw, mw, rs, ill);
    return '{alu, a, b, rs2, rd, rw, mw, rs, ill};
  endfunction

  function automatic exp_t act();
    return '{ex_alu_control, ex_src_a, ex_src_b, ex_rs2_data, ex_rd, ex_reg_write,
             ex_mem_write, ex_result_src, ex_illegal};
  endfunction

  task automatic chk(string nm, logic [127:0] got, logic [127:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] a, b, input exp_t e, output bit im);
    int n = 0;
    in_instr = ins; in_rs1_data = a; in_rs2_data = b; in_valid = 1; im = 1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      im = 0; n++;
      @(negedge clk);
    end
    if (!in_ready) chk("accept_timeout", 0, 1);
    else q.push_back(e);
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  initial forever begin
    @(negedge clk);
    if (ex_valid && ex_ready) begin
      if (q.size() == 0) chk("unexpected_output", act(), 0);
      else chk("decode", act(), q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("reset_valid", ex_valid, 0);
    chk("reset_fields", act(), 0);
    chk("reset_count", illegal_count, 0);
    chk("reset_in_ready", in_ready, 1);
    ex_ready = 1;
    send(32'h002081B3, 5, 7, E(0, 5, 7, 7, 3, 1, 0, 0, 0), imm);
    chk("latency_valid", ex_valid, 1);
    send(32'h402081B3, 5, 7, E(0, 0, 0, 7, 3, 0, 0, 0, 1), imm);
    chk("count_1", illegal_count, 1);
    send(32'h00208063, 1, 2, E(0, 0, 0, 2, 0, 0, 0, 0, 1), imm);
    chk("count_2", illegal_count, 2);
    send(32'hFFF00293, 9, 3, E(0, 9, 32'hFFFFFFFF, 3, 5, 1, 0, 0, 0), imm);
    send(32'h0020A423, 100, 32'hDEADBEEF, E(0, 100, 8, 32'hDEADBEEF, 8, 0, 1, 0, 0), imm);
    send(32'h0020F233, 11, 6, E(1, 11, 6, 6, 4, 1, 0, 0, 0), imm);
    chk("stream_and", imm, 1);
    send(32'h0020E333, 12, 5, E(3, 12, 5, 5, 6, 1, 0, 0, 0), imm);
    chk("stream_or", imm, 1);
    send(32'h002093B3, 1, 4, E(4, 1, 4, 4, 7, 1, 0, 0, 0), imm);
    chk("stream_sll", imm, 1);
    send(32'h00509413, 3, 0, E(4, 3, 5, 0, 8, 1, 0, 0, 0), imm);
    chk("stream_slli", imm, 1);
    send(32'hFF00F493, 32'h1234, 0, E(1, 32'h1234, 32'hFFFFFFF0, 0, 9, 1, 0, 0, 0), imm);
    send(32'hFFC0A503, 32'h2000, 0, E(0, 32'h2000, 32'hFFFFFFFC, 0, 10, 1, 0, 1, 0), imm);
    send(32'h00208033, 1, 2, E(0, 1, 2, 2, 0, 0, 0, 0, 0), imm);
    chk("rd0_valid", ex_valid, 1);
    chk("rd0_reg_write", ex_reg_write, 0);
    send(32'h40509413, 3, 0, E(0, 0, 0, 0, 8, 0, 0, 0, 1), imm);
    chk("count_3", illegal_count, 3);
    send(32'h000012B7, 1, 1, E(0, 0, 0, 1, 5, 0, 0, 0, 1), imm);
    send(32'h402081B3, 2, 3, E(0, 0, 0, 3, 3, 0, 0, 0, 1), imm);
    chk("count_5", illegal_count, 5);
    chk("count_saturated", d2_count, 3);
    // stall: A held, B waiting with ex_ready low
    A = E(0, 5, 7, 7, 3, 1, 0, 0, 0);
    B = E(3, 12, 5, 5, 6, 1, 0, 0, 0);
    send(32'h002081B3, 5, 7, A, imm);
    ex_ready = 0;
    in_instr = 32'h0020E333; in_rs1_data = 12; in_rs2_data = 5; in_valid = 1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_hold", act(), A);
      chk("stall_count", illegal_count, 5);
    end
    @(posedge clk); #1;
    ex_ready = 1;
    send(32'h0020E333, 12, 5, B, imm);
    chk("unstall_rd", ex_rd, 6);
    // flush with a legal incoming instruction while one is held
    send(32'h0020F233, 11, 6, E(1, 11, 6, 6, 4, 1, 0, 0, 0), imm);
    in_instr = 32'hFFF00293; in_rs1_data = 9; in_valid = 1; flush = 1;
    @(posedge clk); #1;
    flush = 0; in_valid = 0;
    chk("flush_valid", ex_valid, 0);
    chk("flush_reg_write", ex_reg_write, 0);
    chk("flush_count", illegal_count, 5);
    // flush with an illegal incoming instruction must not count
    send(32'h0020A423, 1, 2, E(0, 1, 8, 2, 8, 0, 1, 0, 0), imm);
    in_instr = 32'h402081B3; in_valid = 1; flush = 1;
    @(posedge clk); #1;
    flush = 0; in_valid = 0;
    chk("flush_ill_valid", ex_valid, 0);
    chk("flush_ill_flag", ex_illegal, 0);
    chk("flush_ill_mem_write", ex_mem_write, 0);
    chk("flush_ill_count", illegal_count, 5);
    send(32'h002081B3, 21, 22, E(0, 21, 22, 22, 3, 1, 0, 0, 0), imm);
    chk("recover_accept", imm, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("drained", q.size(), 0);
    chk("idle_valid", ex_valid, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/id_ex_issue.md
# id_ex_issue

Decode-and-issue stage feeding the execute-stage ALU of the RISC-V pipeline. It decodes a fetched instruction into the ALU control code and operands (SrcA, SrcB), plus the write-back and memory control bits. The result is held in a single-entry ID/EX pipeline register with a valid/ready handshake, stall and flush. It also flags unsupported instructions and counts them in a saturating counter.

## Interface
- CNT_W, 16, width of the illegal-instruction counter

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  upstream has an instruction
- in_ready  out  1  stage can accept this cycle
- in_instr  in  32  instruction word
- in_rs1_data  in  32  register-file read of instr[19:15]
- in_rs2_data  in  32  register-file read of instr[24:20]
- flush  in  1  discard held and incoming instruction
- ex_ready  in  1  execute stage consumes ex_* this cycle
- ex_valid  out  1  ex_* outputs hold an instruction
- ex_alu_control  out  4  ALU operation code
- ex_src_a  out  32  ALU operand A
- ex_src_b  out  32  ALU operand B
- ex_rs2_data  out  32  store data
- ex_rd  out  5  destination register
- ex_reg_write  out  1  write-back enable
- ex_mem_write  out  1  store enable
- ex_result_src  out  1  0 = ALU result, 1 = load data
- ex_illegal  out  1  held instruction is unsupported
- illegal_count  out  CNT_W  saturating count of accepted illegal instructions

## Operation
- ALU codes: ADD 4'b0000, AND 4'b0001, OR 4'b0011, SLL 4'b0100. No other code is ever emitted.
- Supported opcodes:
  - R-type 0110011, funct7 = 0000000 required: funct3 000 ADD, 111 AND, 110 OR, 001 SLL.
  - I-ALU 0010011: funct3 000 ADD, 111 AND, 110 OR; 001 SLL only when instr[31:25] = 0.
  - Load 0000011: funct3 010 only. ADD, result_src = 1.
  - Store 0100011: funct3 010 only. ADD, mem_write = 1, reg_write = 0.
- Operand A is always in_rs1_data.
- Operand B by class:
  - R-type: in_rs2_data.
  - I-ALU and load: sign-extended instr[31:20]. For SLL-immediate it is the zero-extended shamt instr[24:20].
  - Store: sign-extended {instr[31:25], instr[11:7]}.
- Reg_write is 1 for R, I-ALU and load, and is forced to 0 when rd = x0.
- Illegal (anything else, including SUB, branches and LUI) is still accepted:
  - ex_illegal = 1.
  - reg_write = mem_write = result_src = 0, alu_control = 0000.
  - src_a and src_b = 0.
- illegal_count increments by 1 on each accepted illegal instruction not cancelled by flush. It saturates at all-ones.

## Timing
- Reset (synchronous): ex_valid = 0, all ex_* data and control outputs = 0, illegal_count = 0. in_ready = 1 in the first cycle after reset.
- in_ready = !ex_valid || ex_ready. It is combinational and does not depend on in_valid or flush.
- Accept = in_valid && in_ready. On accept, the decoded fields load at the next edge and ex_valid = 1. Latency is 1 cycle.
- Held instruction consumed (ex_valid && ex_ready) with no accept in the same cycle: ex_valid <= 0 next cycle.
- Consume and accept in the same cycle: the new instruction replaces the old one with no bubble, so back-to-back throughput is 1 per cycle.
- Stall (ex_valid && !ex_ready):
  - every ex_* output holds bit-stable;
  - in_ready = 0;
  - the counter is unchanged.
- Flush has top priority:
  - next-cycle ex_valid = 0 and control bits (reg_write, mem_write, illegal) = 0;
  - any same-cycle accept is discarded, and the counter does not count it;
  - data outputs may hold stale values.
- rst has priority over flush and accept.
- Outputs are decoded combinationally from in_* and registered once. No combinational path exists from in_* to ex_*.

## Test plan
- Decode after reset: rst for 2 cycles, then add x3,x1,x2 (0x002081B3) with rs1 = 5 and rs2 = 7.
  - Next cycle: ex_valid = 1, alu_control = 0000, src_a = 5, src_b = 7, rd = 3, reg_write = 1.
- Immediates: addi x5,x0,-1 (0xFFF00293) gives src_b = 0xFFFFFFFF. sw x2,8(x1) (0x0020A423) gives src_b = 8, mem_write = 1, reg_write = 0, ex_rs2_data = rs2.
- Stall: hold ex_ready = 0 for 3 cycles with in_valid = 1.
  - in_ready = 0 throughout and ex_* are unchanged.
  - Raise ex_ready: the next instruction appears 1 cycle later. Streaming then reaches 1 instruction per cycle.
- Illegal: sub (0x402081B3) and beq (0x00208063).
  - Each gives ex_illegal = 1, all controls 0, and illegal_count steps 0→1→2.
  - A preloaded count of 0xFFFF stays at 0xFFFF.
- Flush: assert flush together with an accepted legal instruction while another is held. Next cycle ex_valid = 0 and the counter is unchanged.
- rd = x0: add x0,x1,x2 (0x00208033) gives reg_write = 0 with ex_valid = 1.
